// File: rtl/branch_sequencer_pkg.sv
// Shared ALU opcodes, branch compare codes, request kinds and sequencer states
// for the branch sequencer and anything else that drives the core ALU.
package branch_sequencer_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_AND  = 4'd6;

  localparam logic [2:0] ALU_CMP_EQ  = 3'd0;
  localparam logic [2:0] ALU_CMP_NE  = 3'd1;
  localparam logic [2:0] ALU_CMP_LT  = 3'd4;
  localparam logic [2:0] ALU_CMP_GE  = 3'd5;
  localparam logic [2:0] ALU_CMP_LTU = 3'd6;
  localparam logic [2:0] ALU_CMP_GEU = 3'd7;

  localparam logic [1:0] BR_KIND_BRANCH = 2'd0;
  localparam logic [1:0] BR_KIND_JAL    = 2'd1;
  localparam logic [1:0] BR_KIND_JALR   = 2'd2;
  localparam logic [1:0] BR_KIND_RSVD   = 2'd3;

  typedef enum logic [1:0] {
    BR_SEQ_ST_IDLE  = 2'd0,
    BR_SEQ_ST_CMP   = 2'd1,
    BR_SEQ_ST_TGT   = 2'd2,
    BR_SEQ_ST_REDIR = 2'd3
  } br_seq_st_e;

  function automatic logic br_is_jump(input logic [1:0] kind);
    return (kind == BR_KIND_JAL) || (kind == BR_KIND_JALR);
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition unit: picks the ALU compare opcode for a
// branch compare code and evaluates taken from the ALU result.
module branch_cond
  import branch_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_cmp_opcode,
  input  logic [XLEN-1:0] i_alu_result,
  output logic [3:0]      o_alu_opcode,
  output logic            o_taken
);

  logic w_zero;
  assign w_zero = (i_alu_result == '0);

  always_comb begin
    o_alu_opcode = ALU_XOR;
    o_taken      = 1'b0;
    case (i_cmp_opcode)
      ALU_CMP_EQ:  begin o_alu_opcode = ALU_XOR;  o_taken = w_zero;           end
      ALU_CMP_NE:  begin o_alu_opcode = ALU_XOR;  o_taken = !w_zero;          end
      ALU_CMP_LT:  begin o_alu_opcode = ALU_SLT;  o_taken = i_alu_result[0];  end
      ALU_CMP_GE:  begin o_alu_opcode = ALU_SLT;  o_taken = !i_alu_result[0]; end
      ALU_CMP_LTU: begin o_alu_opcode = ALU_SLTU; o_taken = i_alu_result[0];  end
      ALU_CMP_GEU: begin o_alu_opcode = ALU_SLTU; o_taken = !i_alu_result[0]; end
      default:     begin o_alu_opcode = ALU_XOR;  o_taken = 1'b0;             end
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// Multi-cycle branch/JAL/JALR resolver time-sharing the core ALU (compare pass,
// target pass, redirect handshake). Optional BRANCH_SEQ_MISALIGN_EN traps misaligned targets.
module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_kind,
  input  logic [2:0]      req_cmp_opcode,
  input  logic [XLEN-1:0] req_pc,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [XLEN-1:0] req_imm,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_opcode,
  input  logic [XLEN-1:0] alu_result,
  output logic            alu_own,
  output logic            redirect_valid,
  input  logic            redirect_ready,
  output logic [XLEN-1:0] redirect_pc,
`ifdef BRANCH_SEQ_MISALIGN_EN
  output logic            misalign,
`endif
  output logic            done,
  output logic            done_taken,
  output logic            link_valid,
  output logic [XLEN-1:0] link_data
);

  br_seq_st_e      r_state;
  br_seq_st_e      w_next;
  logic [1:0]      r_kind;
  logic [2:0]      r_cmp_op;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rs1;
  logic [XLEN-1:0] r_rs2;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_target;
  logic [XLEN-1:0] r_link;

  logic            w_accept;
  logic            w_tgt_load;
  logic [3:0]      w_cond_op;
  logic            w_cond_taken;
  logic            w_jump;

  assign w_jump = br_is_jump(r_kind);

  branch_cond #(.XLEN(XLEN)) u_cond (
    .i_cmp_opcode (r_cmp_op),
    .i_alu_result (alu_result),
    .o_alu_opcode (w_cond_op),
    .o_taken      (w_cond_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= BR_SEQ_ST_IDLE;
    else        r_state <= w_next;
  end

  // Operand/target storage carries no reset; outputs derived from it are gated by state.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_kind   <= req_kind;
      r_cmp_op <= req_cmp_opcode;
      r_pc     <= req_pc;
      r_rs1    <= req_rs1;
      r_rs2    <= req_rs2;
      r_imm    <= req_imm;
      r_link   <= req_pc + XLEN'(4);
    end
    if (w_tgt_load)
      r_target <= {alu_result[XLEN-1:1], alu_result[0] & (r_kind != BR_KIND_JALR)};
  end

  always_comb begin
    w_next         = r_state;
    w_accept       = 1'b0;
    w_tgt_load     = 1'b0;
    req_ready      = 1'b0;
    alu_own        = 1'b0;
    alu_a          = '0;
    alu_b          = '0;
    alu_opcode     = '0;
    redirect_valid = 1'b0;
    done           = 1'b0;
    done_taken     = 1'b0;
    link_valid     = 1'b0;
`ifdef BRANCH_SEQ_MISALIGN_EN
    misalign       = 1'b0;
`endif
    case (r_state)
      BR_SEQ_ST_IDLE: begin
        req_ready = !flush;
        if (req_valid && !flush) begin
          w_accept = 1'b1;
          w_next   = br_is_jump(req_kind) ? BR_SEQ_ST_TGT : BR_SEQ_ST_CMP;
        end
      end
      BR_SEQ_ST_CMP: begin
        alu_own    = 1'b1;
        alu_a      = r_rs1;
        alu_b      = r_rs2;
        alu_opcode = w_cond_op;
        if (flush) begin
          w_next = BR_SEQ_ST_IDLE;
        end else if (w_cond_taken && (r_kind != BR_KIND_RSVD)) begin
          w_next = BR_SEQ_ST_TGT;
        end else begin
          done   = 1'b1;
          w_next = BR_SEQ_ST_IDLE;
        end
      end
      BR_SEQ_ST_TGT: begin
        alu_own    = 1'b1;
        alu_a      = (r_kind == BR_KIND_JALR) ? r_rs1 : r_pc;
        alu_b      = r_imm;
        alu_opcode = ALU_ADD;
        if (flush) begin
          w_next = BR_SEQ_ST_IDLE;
        end else begin
          w_tgt_load = 1'b1;
          w_next     = BR_SEQ_ST_REDIR;
        end
      end
      BR_SEQ_ST_REDIR: begin
`ifdef BRANCH_SEQ_MISALIGN_EN
        if (r_target[1:0] != 2'b00) begin
          misalign   = !flush;
          done       = !flush;
          done_taken = !flush;
          w_next     = BR_SEQ_ST_IDLE;
        end else
`endif
        begin
          // A handshake that lands together with flush still completes.
          redirect_valid = 1'b1;
          if (redirect_ready) begin
            done       = 1'b1;
            done_taken = 1'b1;
            link_valid = w_jump;
            w_next     = BR_SEQ_ST_IDLE;
          end else if (flush) begin
            w_next = BR_SEQ_ST_IDLE;
          end
        end
      end
      default: w_next = BR_SEQ_ST_IDLE;
    endcase
  end

  assign redirect_pc = redirect_valid ? r_target : '0;
  assign link_data   = link_valid ? r_link : '0;

endmodule

// File: tb/tb_branch_sequencer.sv
// Randomized and directed bench for branch_sequencer with a behavioural ALU and
// a specification-level reference model of branch resolution.
module tb_branch_sequencer;
  import branch_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_kind = '0;
  logic [2:0]  req_cmp_opcode = '0;
  logic [31:0] req_pc = '0, req_rs1 = '0, req_rs2 = '0, req_imm = '0;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_opcode;
  logic        alu_own;
  logic        redirect_valid;
  logic        redirect_ready = 1'b0;
  logic [31:0] redirect_pc;
  logic        done, done_taken, link_valid;
  logic [31:0] link_data;
`ifdef BRANCH_SEQ_MISALIGN_EN
  logic        misalign;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  branch_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_cmp_opcode(req_cmp_opcode), .req_pc(req_pc), .req_rs1(req_rs1),
    .req_rs2(req_rs2), .req_imm(req_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
    .alu_own(alu_own), .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc),
`ifdef BRANCH_SEQ_MISALIGN_EN
    .misalign(misalign),
`endif
    .done(done), .done_taken(done_taken), .link_valid(link_valid), .link_data(link_data)
  );

  // Behavioural core ALU shared with the sequencer.
  always_comb begin
    alu_result = '0;
    case (alu_opcode)
      ALU_ADD:  alu_result = alu_a + alu_b;
      ALU_SUB:  alu_result = alu_a - alu_b;
      ALU_XOR:  alu_result = alu_a ^ alu_b;
      ALU_SLT:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_result = {31'd0, alu_a < alu_b};
      default:  alu_result = '0;
    endcase
  end

  function automatic void model(input logic [1:0] kind, input logic [2:0] op,
                                input logic [31:0] pc, rs1, rs2, imm,
                                output bit taken, output logic [31:0] tgt,
                                output logic [31:0] link, output bit jump);
    bit c;
    case (op)
      3'd0: c = (rs1 == rs2);
      3'd1: c = (rs1 != rs2);
      3'd4: c = ($signed(rs1) <  $signed(rs2));
      3'd5: c = ($signed(rs1) >= $signed(rs2));
      3'd6: c = (rs1 <  rs2);
      3'd7: c = (rs1 >= rs2);
      default: c = 1'b0;
    endcase
    jump  = (kind == 2'd1) || (kind == 2'd2);
    taken = jump ? 1'b1 : ((kind == 2'd3) ? 1'b0 : c);
    tgt   = (kind == 2'd2) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
    link  = pc + 32'd4;
  endfunction

  function automatic logic [3:0] exp_cmp_opcode(input logic [2:0] op);
    if (op == 3'd0 || op == 3'd1) return ALU_XOR;
    if (op == 3'd4 || op == 3'd5) return ALU_SLT;
    return ALU_SLTU;
  endfunction

  // One full request from acceptance to return to IDLE, with `stall` cycles of ready low.
  task automatic run_req(input string nm, input logic [1:0] kind, input logic [2:0] op,
                         input logic [31:0] pc, rs1, rs2, imm, input int stall);
    bit taken, jump;
    logic [31:0] tgt, link;
    model(kind, op, pc, rs1, rs2, imm, taken, tgt, link, jump);
    @(negedge clk);
    req_valid = 1'b1; req_kind = kind; req_cmp_opcode = op;
    req_pc = pc; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm; redirect_ready = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s accept: req_ready=%b required 1", nm, req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    if (!jump) begin
      n_tests++;
      if (alu_own !== 1'b1 || (op[1:0] != 2'd2 && op != 3'd3 && alu_opcode !== exp_cmp_opcode(op))) begin
        n_fail++; $display("FAIL %s cmp: own=%b op=%0d required own=1 op=%0d", nm, alu_own, alu_opcode, exp_cmp_opcode(op));
      end
      n_tests++;
      if ({done, done_taken, redirect_valid} !== {!taken, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL %s cmp_done: done/taken/rv=%b%b%b required %b00", nm, done, done_taken, redirect_valid, !taken);
      end
      if (!taken) return;
      @(negedge clk);
      #1;
    end
    n_tests++;
    if (alu_own !== 1'b1 || alu_opcode !== ALU_ADD || done !== 1'b0) begin
      n_fail++; $display("FAIL %s tgt: own=%b op=%0d done=%b required 1/%0d/0", nm, alu_own, alu_opcode, done, ALU_ADD);
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      #1;
      n_tests++;
      if ({redirect_valid, done, alu_own} !== 3'b100 || redirect_pc !== tgt) begin
        n_fail++; $display("FAIL %s stall%0d: rv/done/own=%b%b%b pc=%h required 100 pc=%h", nm, s, redirect_valid, done, alu_own, redirect_pc, tgt);
      end
    end
    @(negedge clk);
    redirect_ready = 1'b1;
    #1;
    n_tests++;
    if ({redirect_valid, done, done_taken, link_valid} !== {3'b111, jump} || redirect_pc !== tgt) begin
      n_fail++; $display("FAIL %s redir: rv/d/dt/lv=%b%b%b%b pc=%h required 111%b pc=%h", nm, redirect_valid, done, done_taken, link_valid, redirect_pc, {31'd0, jump}, tgt);
    end
    if (jump) begin
      n_tests++;
      if (link_data !== link) begin
        n_fail++; $display("FAIL %s link: link_data=%h required %h", nm, link_data, link);
      end
    end
    @(negedge clk);
    redirect_ready = 1'b0;
    #1;
    n_tests++;
    if ({req_ready, done, redirect_valid} !== 3'b100) begin
      n_fail++; $display("FAIL %s idle: ready/done/rv=%b%b%b required 100", nm, req_ready, done, redirect_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_tests++;
    if ({req_ready, alu_own, redirect_valid, done, done_taken, link_valid} !== 6'b100000 ||
        alu_a !== 0 || alu_b !== 0 || alu_opcode !== 0 || redirect_pc !== 0 || link_data !== 0) begin
      n_fail++; $display("FAIL reset: ready=%b own=%b rv=%b done=%b pc=%h required ready=1 rest 0", req_ready, alu_own, redirect_valid, done, redirect_pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_req("beq",  BR_KIND_BRANCH, ALU_CMP_EQ,  32'h100, 32'd5, 32'd5, 32'h20, 0);
    run_req("bltu", BR_KIND_BRANCH, ALU_CMP_LTU, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10, 0);
    run_req("blt",  BR_KIND_BRANCH, ALU_CMP_LT,  32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10, 1);
    run_req("jalr", BR_KIND_JALR,   3'd0,        32'h40, 32'h1003, 32'd0, 32'd2, 0);
    run_req("jal_wrap", BR_KIND_JAL, 3'd0,       32'hFFFF_FFFC, 32'd0, 32'd0, 32'd8, 4);
    run_req("rsvd", BR_KIND_RSVD,   ALU_CMP_EQ,  32'h300, 32'd7, 32'd7, 32'h8, 0);
    run_req("bge_wrap", BR_KIND_BRANCH, ALU_CMP_GE, 32'hFFFF_FFF0, 32'd3, 32'hFFFF_FFFF, 32'h20, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      run_req("b2b", BR_KIND_BRANCH, ALU_CMP_NE, 32'h1000 + 32'(i), 32'(i), 32'(i), 32'h4, 0);
  endtask

  task automatic test_flush();
    @(negedge clk);
    req_valid = 1'b1; req_kind = BR_KIND_BRANCH; req_cmp_opcode = ALU_CMP_EQ;
    req_pc = 32'h500; req_rs1 = 32'd9; req_rs2 = 32'd9; req_imm = 32'h40;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_kind = BR_KIND_JAL;
    #1;
    n_tests++;
    if ({alu_own, done, req_ready} !== 3'b100) begin
      n_fail++; $display("FAIL flush_tgt: own/done/ready=%b%b%b required 100", alu_own, done, req_ready);
    end
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    #1;
    n_tests++;
    if ({req_ready, alu_own, redirect_valid, done} !== 4'b1000) begin
      n_fail++; $display("FAIL flush_idle: ready/own/rv/done=%b%b%b%b required 1000", req_ready, alu_own, redirect_valid, done);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if ({alu_own, redirect_valid, done} !== 3'b000) begin
      n_fail++; $display("FAIL flush_noaccept: own/rv/done=%b%b%b required 000", alu_own, redirect_valid, done);
    end
    // Flush in CMP of a not-taken branch suppresses done.
    @(negedge clk);
    req_valid = 1'b1; req_kind = BR_KIND_BRANCH; req_cmp_opcode = ALU_CMP_NE;
    req_rs1 = 32'd1; req_rs2 = 32'd1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b1;
    #1;
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL flush_cmp: done=%b required 0", done);
    end
    @(negedge clk);
    flush = 1'b0;
    run_req("after_flush", BR_KIND_JAL, 3'd0, 32'h600, 32'd0, 32'd0, 32'h100, 0);
    // Flush together with the redirect handshake.
    @(negedge clk);
    req_valid = 1'b1; req_kind = BR_KIND_JAL; req_pc = 32'h700; req_imm = 32'h10;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1; redirect_ready = 1'b1;
    #1;
    n_tests++;
    if ({redirect_valid, done, done_taken, link_valid} !== 4'b1111 || redirect_pc !== 32'h710 || link_data !== 32'h704) begin
      n_fail++; $display("FAIL flush_hs: rv/d/dt/lv=%b%b%b%b pc=%h link=%h required 1111 710 704", redirect_valid, done, done_taken, link_valid, redirect_pc, link_data);
    end
    @(negedge clk);
    flush = 1'b0; redirect_ready = 1'b0;
    #1;
    n_tests++;
    if ({req_ready, done, redirect_valid} !== 3'b100) begin
      n_fail++; $display("FAIL flush_hs_idle: ready/done/rv=%b%b%b required 100", req_ready, done, redirect_valid);
    end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    req_valid = 1'b1; req_kind = BR_KIND_JAL; req_pc = 32'h800; req_imm = 32'h20;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    n_tests++;
    if (redirect_valid !== 1'b1) begin
      n_fail++; $display("FAIL midop_pre: rv=%b required 1", redirect_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({req_ready, alu_own, redirect_valid, done, link_valid} !== 5'b10000 || redirect_pc !== 0) begin
      n_fail++; $display("FAIL midop_reset: ready/own/rv/done/lv=%b%b%b%b%b pc=%h required 10000 0", req_ready, alu_own, redirect_valid, done, link_valid, redirect_pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef BRANCH_SEQ_MISALIGN_EN
  task automatic test_misalign();
    @(negedge clk);
    req_valid = 1'b1; req_kind = BR_KIND_JAL; req_pc = 32'h0; req_imm = 32'd6;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    n_tests++;
    if ({misalign, redirect_valid, done, done_taken, link_valid} !== 5'b10110) begin
      n_fail++; $display("FAIL misalign: m/rv/d/dt/lv=%b%b%b%b%b required 10110", misalign, redirect_valid, done, done_taken, link_valid);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if ({misalign, done, req_ready} !== 3'b001) begin
      n_fail++; $display("FAIL misalign_idle: m/d/ready=%b%b%b required 001", misalign, done, req_ready);
    end
  endtask
`endif

  task automatic test_random();
    logic [2:0] ops [8] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2, 3'd3};
    for (int i = 0; i < 60; i++) begin
      logic [1:0] k;
      logic [31:0] a, b, im, pc;
      k  = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      im = $urandom;
      pc = {$urandom, 2'b00} >> 0;
      run_req("rand", k, ops[$urandom_range(0, 7)], pc, a, b, im, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
`ifdef BRANCH_SEQ_MISALIGN_EN
    test_misalign();
`endif
    test_random();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
